imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the byte-wide, little-endian instruction memory that the fetch path reads as {b[PC+3],b[PC+2],b[PC+1],b[PC]}.
- Accepts 32-bit instruction words over a valid/ready stream (boot/debug link) and writes them as four sequential byte writes into the instruction RAM.
- Holds the CPU in stall until loading completes.

Parameters:
- ADDRESS_WIDTH, 12, byte-address width of instruction memory (4096 bytes).
- DATA_WIDTH, 8, memory byte-lane width; fixed at 8, four lanes per word.
- LOAD_WORDS, 1024, maximum words per load session; reaching it ends the session.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE.
- load_base  input  ADDRESS_WIDTH  start byte address, sampled on an accepted start; bits [1:0] forced to 0.
- in_valid  input  1  word available.
- in_data  input  32  instruction word; byte 0 = in_data[7:0].
- in_last  input  1  qualifies in_data as the final word of the session.
- in_ready  output  1  loader can accept a word this cycle.
- mem_we  output  1  byte write strobe to instruction RAM.
- mem_addr  output  ADDRESS_WIDTH  byte write address.
- mem_wdata  output  DATA_WIDTH  byte write data.
- cpu_hold  output  1  high while the CPU must not fetch.
- done  output  1  load session complete.
- wrapped  output  1  sticky: a write address wrapped past 2**ADDRESS_WIDTH-1 this session.

Behaviour:
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, cpu_hold=1, done=0, wrapped=0. Word buffer and counters are cleared.
- States:
  - IDLE: waiting for start.
  - LOAD: streaming words.
  - DONE: cpu_hold=0, done=1.
- Transitions:
  - IDLE/DONE + start: go to LOAD. Latch next_addr = {load_base[AW-1:2],2'b00}. Clear word_count and wrapped. Set cpu_hold=1, done=0.
  - start is ignored in LOAD.
- Internal 1-word buffer: buf_full, byte index idx (2 bits).
- in_ready = (state==LOAD) && (!buf_full || (idx==3 && !last_latched)) && (word_count < LOAD_WORDS).
- Accept occurs when in_valid && in_ready. It latches in_data and in_last into the buffer, sets buf_full, and sets idx=0 for the next cycle.
- Writes: one byte per cycle while buf_full. Outputs are registered:
  - mem_we=1
  - mem_addr = next_addr
  - mem_wdata = buf[8*idx +: 8]
- Each write increments next_addr by 1, modulo 2**ADDRESS_WIDTH. A wrap from all-ones to 0 sets wrapped.
- Latency: the first byte write appears on the cycle after accept. Bytes 0..3 appear on 4 consecutive cycles.
- Back-to-back: an accept during the idx==3 write reloads the buffer, giving 1 word per 4 cycles with no bubble. Without a concurrent accept, buf_full clears after idx==3.
- Session end: after the idx==3 write of a word that has in_last=1, or of word number LOAD_WORDS, the next state is DONE. cpu_hold falls and done rises on the same edge; no further writes occur.
- mem_we=0 in every cycle with no byte pending. mem_addr and mem_wdata hold their last value when mem_we=0.
- Counters: word_count has width clog2(LOAD_WORDS)+1 and increments on accept.
- in_valid with in_ready low is not an accept; the source holds the word.
- rst during LOAD: on the next edge, return to the reset values. A pending buffered word is discarded, and no write is issued in the cycle after rst.
- rst has priority over start, in_valid and all writes.

Decomposition:
- Package imem_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t.
  - localparam BYTES_PER_WORD = 4.
  - Byte-select helper function byte_of(word, idx).
- One natural sub-module, word_to_bytes_ser: the 32-bit buffer plus idx serializer with the accept-at-idx3 overlap. The FSM, address and counter logic stay in imem_loader.

Test Plan:
1. Single word: rst, start with load_base=0x000, in_data=0x00A00093 with in_last=1. Required: writes (0x000,0x93), (0x001,0x00), (0x002,0xA0), (0x003,0x00) on cycles 1–4 after accept. done=1 and cpu_hold=0 on the following cycle.
2. Streaming: in_valid held high, 4 words 0x11111111..0x44444444, last on word 4. Required: 16 consecutive cycles with mem_we=1 at addresses 0x000..0x00F. in_ready is high only on the idx==3 cycles (plus the first accept).
3. Base/alignment and wrap: load_base=0xFFE (forced to 0xFFC), two words. Required: second word written to 0x000..0x003, wrapped=1, done=1.
4. LOAD_WORDS limit: set LOAD_WORDS=2, send 3 words with in_last=0. Required: only 8 byte writes, third word never accepted (in_ready=0), then DONE.
5. Reset mid-word: assert rst during the idx==1 write. Required: mem_we=0 from the next cycle, state IDLE, cpu_hold=1, done=0. A later start reloads cleanly from the new load_base.
6. Ignored start: pulse start during LOAD with a different load_base. Required: addresses continue sequentially and are unaffected.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_IDX       = 2'(BYTES_PER_WORD - 1);

  // Little-endian byte lane select: idx 0 is word[7:0].
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/word_to_bytes_ser.sv
// One-word buffer that serializes a 32-bit word into four byte slots; a new word may be
// loaded during the last slot so consecutive words stream without a bubble.
module word_to_bytes_ser
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [31:0] word_in,
  input  logic        last_in,
  output logic        buf_full,
  output logic [1:0]  idx,
  output logic        last_latched,
  output logic        issue,
  output logic [7:0]  issue_byte
);

  logic [31:0] buf_q, buf_d;
  logic        full_q, full_d;
  logic [1:0]  idx_q, idx_d;
  logic        last_q, last_d;

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (accept) begin
      buf_d  = word_in;
      last_d = last_in;
      full_d = 1'b1;
      idx_d  = 2'd0;
    end else if (full_q) begin
      if (idx_q == LAST_IDX) begin
        full_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // Look-ahead of the slot occupied next cycle, so the parent can register its outputs.
  assign issue      = full_d;
  assign issue_byte = byte_of(buf_d, idx_d);

  assign buf_full     = full_q;
  assign idx          = idx_q;
  assign last_latched = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      full_q <= 1'b0;
      idx_q  <= 2'd0;
      last_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide RAM as four sequential byte writes,
// holding the CPU off until the load session completes.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LOAD_WORDS    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] load_base,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     wrapped
);

  localparam int unsigned      CW    = $clog2(LOAD_WORDS) + 1;
  localparam logic [CW-1:0]    LIMIT = CW'(LOAD_WORDS);

  loader_state_t              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       wrapped_q, wrapped_d;
  logic                       mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;

  logic       buf_full, last_latched, issue, accept, session_end;
  logic [1:0] idx;
  logic [7:0] issue_byte;

  word_to_bytes_ser u_ser (
    .clk          (clk),
    .rst          (rst),
    .accept       (accept),
    .word_in      (in_data),
    .last_in      (in_last),
    .buf_full     (buf_full),
    .idx          (idx),
    .last_latched (last_latched),
    .issue        (issue),
    .issue_byte   (issue_byte)
  );

  assign in_ready = (state_q == LOAD)
                  && (!buf_full || (idx == LAST_IDX && !last_latched))
                  && (count_q < LIMIT);
  assign accept   = in_valid && in_ready;

  // The buffered word is always word number count_q, so the limit test needs no lookahead.
  assign session_end = buf_full && (idx == LAST_IDX) && (last_latched || count_q == LIMIT);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          addr_d    = load_base & ~ADDRESS_WIDTH'(3);
          count_d   = '0;
          wrapped_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          count_d = count_q + CW'(1);
        end
        if (issue) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = issue_byte;
          addr_d      = addr_q + ADDRESS_WIDTH'(1);
          if (&addr_q) begin
            wrapped_d = 1'b1;
          end
        end
        if (session_end) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a second instance with LOAD_WORDS=2 covers the word limit.
module tb_imem_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_last;
  logic [11:0] load_base;
  logic [31:0] in_data;

  logic        in_ready, mem_we, cpu_hold, done, wrapped;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        in_ready2, mem_we2, cpu_hold2, done2, wrapped2;
  logic [11:0] mem_addr2;
  logic [7:0]  mem_wdata2;

  imem_loader #(.ADDRESS_WIDTH(12), .DATA_WIDTH(8), .LOAD_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .load_base(load_base), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
    .wrapped(wrapped)
  );

  imem_loader #(.ADDRESS_WIDTH(12), .DATA_WIDTH(8), .LOAD_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .load_base(load_base), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .cpu_hold(cpu_hold2), .done(done2),
    .wrapped(wrapped2)
  );

  bit          use2 = 1'b0;
  logic        rdy_s, we_s, done_s;
  logic [11:0] addr_s;
  logic [7:0]  data_s;
  assign rdy_s  = use2 ? in_ready2  : in_ready;
  assign we_s   = use2 ? mem_we2    : mem_we;
  assign done_s = use2 ? done2      : done;
  assign addr_s = use2 ? mem_addr2  : mem_addr;
  assign data_s = use2 ? mem_wdata2 : mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          c;
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         wr_q[$];
  int          rdy_q[$];
  int          acc_q[$];
  int          done_cyc;
  logic [31:0] words[4];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [11:0] base);
    start     = 1'b1;
    load_base = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Valid/ready source plus a per-cycle log of writes, ready cycles and accept edges.
  task automatic send_words(input int n, input bit last_end, input int start_at,
                            input logic [11:0] alt_base);
    int wi = 0;
    bit acc;
    wr_q.delete();
    rdy_q.delete();
    acc_q.delete();
    done_cyc = -1;
    in_valid = 1'b1;
    in_data  = words[0];
    in_last  = last_end && (n == 1);
    for (int t = 0; t < 200; t++) begin
      if (t == start_at) begin
        start     = 1'b1;
        load_base = alt_base;
      end else begin
        start = 1'b0;
      end
      if (we_s) wr_q.push_back('{cyc, addr_s, data_s});
      if (done_s) begin
        done_cyc = cyc;
        break;
      end
      if (rdy_s) rdy_q.push_back(cyc);
      acc = in_valid && rdy_s;
      if (acc) acc_q.push_back(cyc + 1);
      @(negedge clk);
      if (acc) begin
        wi++;
        if (wi >= n) begin
          in_valid = 1'b0;
        end else begin
          in_data = words[wi];
          in_last = last_end && (wi == n - 1);
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 12'h000) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (wrapped !== 1'b0) begin n_bad++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
  endtask

  task automatic test_single();
    logic [7:0] ed[4] = '{8'h93, 8'h00, 8'hA0, 8'h00};
    int fc;
    use2 = 1'b0;
    do_start(12'h000);
    words[0] = 32'h00A00093;
    send_words(1, 1'b1, -1, 12'h000);
    fc = (acc_q.size() > 0) ? acc_q[0] : -1000;
    n_cmp++; if (wr_q.size() != 4) begin n_bad++; $display("FAIL single_count: got %0d writes want 4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= wr_q.size()) begin
        n_bad++; $display("FAIL single_byte%0d: got no write want addr=%h", i, 12'(i));
      end else if (wr_q[i].a !== 12'(i) || wr_q[i].d !== ed[i] || wr_q[i].c != fc + i) begin
        n_bad++;
        $display("FAIL single_byte%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wr_q[i].a, wr_q[i].d, wr_q[i].c, 12'(i), ed[i], fc + i);
      end
    end
    n_cmp++; if (done_cyc != fc + 4) begin n_bad++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc, fc + 4); end
    n_cmp++;
    if ({done, cpu_hold, wrapped, mem_we} !== 4'b1000) begin
      n_bad++; $display("FAIL single_end: got done,hold,wrapped,we=%b want 1000", {done, cpu_hold, wrapped, mem_we});
    end
  endtask

  task automatic test_stream();
    int fc;
    logic [7:0] eb;
    use2 = 1'b0;
    do_start(12'h000);
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_words(4, 1'b1, -1, 12'h000);
    fc = (acc_q.size() > 0) ? acc_q[0] : -1000;
    n_cmp++; if (wr_q.size() != 16) begin n_bad++; $display("FAIL stream_count: got %0d writes want 16", wr_q.size()); end
    for (int i = 0; i < 16; i++) begin
      eb = 8'(8'h11 * (i / 4 + 1));
      n_cmp++;
      if (i >= wr_q.size()) begin
        n_bad++; $display("FAIL stream_byte%0d: got no write want addr=%h", i, 12'(i));
      end else if (wr_q[i].a !== 12'(i) || wr_q[i].d !== eb || wr_q[i].c != fc + i) begin
        n_bad++;
        $display("FAIL stream_byte%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wr_q[i].a, wr_q[i].d, wr_q[i].c, 12'(i), eb, fc + i);
      end
    end
    n_cmp++; if (rdy_q.size() != 4) begin n_bad++; $display("FAIL stream_ready_count: got %0d ready cycles want 4", rdy_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= rdy_q.size() || rdy_q[k] != fc - 1 + 4 * k) begin
        n_bad++; $display("FAIL stream_ready%0d: got cyc=%0d want cyc=%0d", k,
                          (k < rdy_q.size()) ? rdy_q[k] : -1, fc - 1 + 4 * k);
      end
    end
    n_cmp++; if (done_cyc != fc + 16) begin n_bad++; $display("FAIL stream_done_cyc: got %0d want %0d", done_cyc, fc + 16); end
  endtask

  task automatic test_wrap();
    logic [7:0] ed[8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [11:0] ea;
    int fc;
    use2 = 1'b0;
    do_start(12'hFFE);
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01234567;
    send_words(2, 1'b1, -1, 12'h000);
    fc = (acc_q.size() > 0) ? acc_q[0] : -1000;
    n_cmp++; if (wr_q.size() != 8) begin n_bad++; $display("FAIL wrap_count: got %0d writes want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      ea = 12'hFFC + 12'(i);
      n_cmp++;
      if (i >= wr_q.size()) begin
        n_bad++; $display("FAIL wrap_byte%0d: got no write want addr=%h", i, ea);
      end else if (wr_q[i].a !== ea || wr_q[i].d !== ed[i] || wr_q[i].c != fc + i) begin
        n_bad++;
        $display("FAIL wrap_byte%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wr_q[i].a, wr_q[i].d, wr_q[i].c, ea, ed[i], fc + i);
      end
    end
    n_cmp++;
    if ({done, cpu_hold, wrapped} !== 3'b101) begin
      n_bad++; $display("FAIL wrap_end: got done,hold,wrapped=%b want 101", {done, cpu_hold, wrapped});
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] ed[8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h88, 8'h77, 8'h66, 8'h55};
    logic [11:0] ea;
    use2 = 1'b0;
    do_start(12'h040);
    words[0] = 32'hA1B2C3D4;
    words[1] = 32'h55667788;
    send_words(2, 1'b1, 6, 12'h800);
    n_cmp++; if (wr_q.size() != 8) begin n_bad++; $display("FAIL ign_count: got %0d writes want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      ea = 12'h040 + 12'(i);
      n_cmp++;
      if (i >= wr_q.size()) begin
        n_bad++; $display("FAIL ign_byte%0d: got no write want addr=%h", i, ea);
      end else if (wr_q[i].a !== ea || wr_q[i].d !== ed[i]) begin
        n_bad++;
        $display("FAIL ign_byte%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, wr_q[i].a, wr_q[i].d, ea, ed[i]);
      end
    end
    n_cmp++;
    if ({done, wrapped} !== 2'b10) begin
      n_bad++; $display("FAIL ign_end: got done,wrapped=%b want 10 (start clears wrapped)", {done, wrapped});
    end
  endtask

  task automatic test_limit();
    logic [7:0] ed[8] = '{8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
    int fc;
    bit leak;
    use2 = 1'b1;
    do_reset();
    do_start(12'h000);
    words[0] = 32'h0BADF00D;
    words[1] = 32'hCAFEBABE;
    words[2] = 32'h12345678;
    send_words(3, 1'b0, -1, 12'h000);
    fc = (acc_q.size() > 0) ? acc_q[0] : -1000;
    n_cmp++; if (wr_q.size() != 8) begin n_bad++; $display("FAIL limit_count: got %0d writes want 8", wr_q.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= wr_q.size()) begin
        n_bad++; $display("FAIL limit_byte%0d: got no write want addr=%h", i, 12'(i));
      end else if (wr_q[i].a !== 12'(i) || wr_q[i].d !== ed[i] || wr_q[i].c != fc + i) begin
        n_bad++;
        $display("FAIL limit_byte%0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wr_q[i].a, wr_q[i].d, wr_q[i].c, 12'(i), ed[i], fc + i);
      end
    end
    n_cmp++; if (acc_q.size() != 2) begin n_bad++; $display("FAIL limit_accepts: got %0d want 2", acc_q.size()); end
    n_cmp++; if (done_cyc != fc + 8) begin n_bad++; $display("FAIL limit_done_cyc: got %0d want %0d", done_cyc, fc + 8); end
    in_valid = 1'b1;
    in_data  = words[2];
    leak = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (in_ready2 !== 1'b0 || mem_we2 !== 1'b0 || done2 !== 1'b1) leak = 1'b1;
    end
    in_valid = 1'b0;
    n_cmp++; if (leak) begin n_bad++; $display("FAIL limit_third_word: got ready/write/done activity want ready=0 we=0 done=1"); end
    use2 = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] ed[4] = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};
    bit got, busy;
    use2 = 1'b0;
    do_reset();
    do_start(12'h200);
    in_valid = 1'b1;
    in_data  = 32'hCAFED00D;
    in_last  = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      if (in_ready) got = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rmw_accept: got in_ready=0 want 1"); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h200, 8'h0D}) begin
      n_bad++; $display("FAIL rmw_byte0: got we=%b addr=%h data=%h want we=1 addr=200 data=0d", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h201, 8'hD0}) begin
      n_bad++; $display("FAIL rmw_byte1: got we=%b addr=%h data=%h want we=1 addr=201 data=d0", mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, in_ready, cpu_hold, done, wrapped} !== {1'b0, 12'h000, 8'h00, 4'b0100}) begin
      n_bad++;
      $display("FAIL rmw_after_rst: got we=%b addr=%h data=%h rdy=%b hold=%b done=%b wr=%b want 0 000 00 0 1 0 0",
               mem_we, mem_addr, mem_wdata, in_ready, cpu_hold, done, wrapped);
    end
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || cpu_hold !== 1'b1) busy = 1'b1;
    end
    n_cmp++; if (busy) begin n_bad++; $display("FAIL rmw_quiet: got write or hold drop after reset want idle"); end
    do_start(12'h312);
    words[0] = 32'h0F1E2D3C;
    send_words(1, 1'b1, -1, 12'h000);
    n_cmp++; if (wr_q.size() != 4) begin n_bad++; $display("FAIL rmw_reload_count: got %0d writes want 4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= wr_q.size()) begin
        n_bad++; $display("FAIL rmw_reload%0d: got no write want addr=%h", i, 12'h310 + 12'(i));
      end else if (wr_q[i].a !== 12'h310 + 12'(i) || wr_q[i].d !== ed[i]) begin
        n_bad++;
        $display("FAIL rmw_reload%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, wr_q[i].a, wr_q[i].d, 12'h310 + 12'(i), ed[i]);
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rmw_reload_done: got %b want 1", done); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    load_base = 12'h000;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_wrap();
    test_ignored_start();
    test_limit();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns want finish");
    $fatal(1, "watchdog timeout");
  end

endmodule
